// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite layer.
package sprite_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned V_VISIBLE = 480;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb4_t;

    // Minimum ROM address width that holds every frame of a w x h sprite.
    function automatic int unsigned spr_addr_w(input int unsigned w,
                                               input int unsigned h,
                                               input int unsigned frames);
        int unsigned n;
        n = w * h * frames;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Position/subpixel counter for one axis of the sprite box.
// Outputs show the post-update state, i.e. the position of the current pixel/line.
module sprite_scan_counter
    import sprite_pkg::*;
#(
    parameter int unsigned CNT_W = 5,
    parameter int unsigned SUB_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic [SUB_W-1:0] scale_i,
    output logic             active_o,
    output logic [CNT_W-1:0] idx_o
);

    logic             active_q, active_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [SUB_W-1:0] sub_q, sub_d;

    // Next state: restart, forced stop, or one scaled step along the axis.
    always_comb begin
        active_d = active_q;
        idx_d    = idx_q;
        sub_d    = sub_q;
        if (start_i) begin
            active_d = 1'b1;
            idx_d    = '0;
            sub_d    = '0;
        end else if (clear_i) begin
            active_d = 1'b0;
        end else if (active_q && step_i) begin
            if (sub_q == scale_i - 1'b1) begin
                sub_d = '0;
                if (idx_q == len_i - 1'b1) begin
                    active_d = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    assign active_o = active_d;
    assign idx_o    = idx_d;

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            idx_q    <= '0;
            sub_q    <= '0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
            sub_q    <= sub_d;
        end
    end

endmodule

// File: rtl/sprite_renderer.sv
// Animated, scaled sprite overlay between the VGA timing and the colour mapper.
// Pipeline: stage 1 ROM address, stage 2 ROM data/palette, stage 3 colour out.
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int unsigned SPR_W           = 20,
    parameter int unsigned SPR_H           = 20,
    parameter int unsigned FRAMES          = 4,
    parameter int unsigned SCALE           = 2,
    parameter int unsigned IDX_W           = 5,
    parameter int unsigned ADDR_W          = 11,
    parameter int unsigned TRANSPARENT_IDX = 0,
    parameter int unsigned ANIM_DIV        = 8
) (
    input  logic              vga_clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              flip_h,
    input  logic              anim_en,
    input  logic [3:0]        bg_red,
    input  logic [3:0]        bg_green,
    input  logic [3:0]        bg_blue,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              hit
);

    localparam int unsigned CNT_W = $clog2(((SPR_W > SPR_H) ? SPR_W : SPR_H) + 1);
    localparam int unsigned SUB_W = 4;
    localparam int unsigned FRM_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int unsigned DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    coord_t            sx_l_q, sy_l_q;
    logic              flip_l_q;
    logic [FRM_W-1:0]  frame_q, frame_d;
    logic [DIV_W-1:0]  div_q, div_d;

    logic              frame_start;
    coord_t            sx_eff, sy_eff;
    logic              flip_eff;

    logic              vstart, hstart, vact, hact;
    logic [CNT_W-1:0]  vrow, hcol, col_sel;
    logic [ADDR_W-1:0] addr_d;
    logic              in_box;

    logic              in_box1_q, blank1_q, in_box2_q, blank2_q;
    rgb4_t             bg1_q, bg2_q;
    rgb4_t             out_q, out_d;
    logic              hit_q, hit_d;

    // Frame-start latch view and animation divider/frame step.
    always_comb begin
        frame_start = (DrawX == '0) && (DrawY == '0);
        sx_eff      = frame_start ? sprite_x : sx_l_q;
        sy_eff      = frame_start ? sprite_y : sy_l_q;
        flip_eff    = frame_start ? flip_h   : flip_l_q;
        frame_d     = frame_q;
        div_d       = div_q;
        if (frame_start && anim_en) begin
            if (div_q == DIV_W'(ANIM_DIV - 1)) begin
                div_d   = '0;
                frame_d = (frame_q == FRM_W'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    assign vstart = (DrawX == '0) && (DrawY == sy_eff) && (sy_eff < coord_t'(V_VISIBLE));
    assign hstart = vact && (DrawX == sx_eff) && (sx_eff < coord_t'(H_VISIBLE));

    // Rows: a frame start drops any box still open from the previous frame.
    sprite_scan_counter #(.CNT_W(CNT_W), .SUB_W(SUB_W)) u_vcnt (
        .clk_i    (vga_clk),
        .rst_i    (Reset),
        .start_i  (vstart),
        .step_i   (DrawX == '0),
        .clear_i  (frame_start),
        .len_i    (CNT_W'(SPR_H)),
        .scale_i  (SUB_W'(SCALE)),
        .active_o (vact),
        .idx_o    (vrow)
    );

    // Columns: DrawX==0 closes a box left open past the end of the line.
    sprite_scan_counter #(.CNT_W(CNT_W), .SUB_W(SUB_W)) u_hcnt (
        .clk_i    (vga_clk),
        .rst_i    (Reset),
        .start_i  (hstart),
        .step_i   (vact),
        .clear_i  (DrawX == '0),
        .len_i    (CNT_W'(SPR_W)),
        .scale_i  (SUB_W'(SCALE)),
        .active_o (hact),
        .idx_o    (hcol)
    );

    // Texel address; the row base is the row index times SPR_W (constant multiply).
    always_comb begin
        col_sel = flip_eff ? (CNT_W'(SPR_W - 1) - hcol) : hcol;
        addr_d  = ADDR_W'(frame_d) * ADDR_W'(SPR_W * SPR_H)
                + ADDR_W'(vrow) * ADDR_W'(SPR_W)
                + ADDR_W'(col_sel);
        in_box  = vact && hact;
    end

    assign pal_index = rom_q;

    // Final colour selection for the pixel whose texel arrives on rom_q.
    always_comb begin
        out_d = '0;
        hit_d = 1'b0;
        if (blank2_q) begin
            if (in_box2_q && (rom_q != IDX_W'(TRANSPARENT_IDX))) begin
                out_d = {pal_red, pal_green, pal_blue};
                hit_d = 1'b1;
            end else begin
                out_d = bg2_q;
            end
        end
    end

    // Latched position, animation state and the three pipeline stages.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            sx_l_q      <= '0;
            sy_l_q      <= '0;
            flip_l_q    <= 1'b0;
            frame_q     <= '0;
            div_q       <= '0;
            rom_address <= '0;
            in_box1_q   <= 1'b0;
            blank1_q    <= 1'b0;
            bg1_q       <= '0;
            in_box2_q   <= 1'b0;
            blank2_q    <= 1'b0;
            bg2_q       <= '0;
            out_q       <= '0;
            hit_q       <= 1'b0;
        end else begin
            if (frame_start) begin
                sx_l_q   <= sprite_x;
                sy_l_q   <= sprite_y;
                flip_l_q <= flip_h;
            end
            frame_q     <= frame_d;
            div_q       <= div_d;
            rom_address <= addr_d;
            in_box1_q   <= in_box;
            blank1_q    <= blank;
            bg1_q       <= {bg_red, bg_green, bg_blue};
            in_box2_q   <= in_box1_q;
            blank2_q    <= blank1_q;
            bg2_q       <= bg1_q;
            out_q       <= out_d;
            hit_q       <= hit_d;
        end
    end

    assign red   = out_q.r;
    assign green = out_q.g;
    assign blue  = out_q.b;
    assign hit   = hit_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: synchronous ROM model (texel = addr mod 31 + 1,
// address 5 transparent), palette red=idx[3:0], green=5, blue=idx[4], bg = A/B/C.
module tb_sprite_renderer;

    logic        vga_clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY, sprite_x, sprite_y;
    logic        blank, flip_h, anim_en;
    logic [3:0]  bg_red, bg_green, bg_blue;
    logic [10:0] rom_address;
    logic [4:0]  rom_q, pal_index;
    logic [3:0]  pal_red, pal_green, pal_blue;
    logic [3:0]  red, green, blue;
    logic        hit;

    int checks   = 0;
    int failures = 0;

    logic [4:0]  rom [0:2047];
    logic [10:0] addr_at [0:1023];
    logic [3:0]  r_at [0:1023];
    logic [3:0]  g_at [0:1023];
    logic [3:0]  b_at [0:1023];
    logic        hit_at [0:1023];

    sprite_renderer #(
        .SPR_W(20), .SPR_H(20), .FRAMES(4), .SCALE(2), .IDX_W(5),
        .ADDR_W(11), .TRANSPARENT_IDX(0), .ANIM_DIV(8)
    ) dut (
        .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .flip_h(flip_h), .anim_en(anim_en),
        .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .rom_address(rom_address), .rom_q(rom_q), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .red(red), .green(green), .blue(blue), .hit(hit)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) rom_q <= rom[rom_address];

    assign pal_red   = pal_index[3:0];
    assign pal_green = 4'h5;
    assign pal_blue  = {3'b000, pal_index[4]};

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Drive one line x=0..xmax; addr_at[x] is the address issued for x,
    // r/g/b/hit_at[x] the output that pixel produces three clocks later.
    task automatic run_line(input int unsigned y, input int unsigned xmax);
        for (int i = 0; i < 1024; i++) begin
            addr_at[i] = 'x; r_at[i] = 'x; g_at[i] = 'x; b_at[i] = 'x; hit_at[i] = 1'bx;
        end
        DrawY = 10'(y);
        for (int unsigned x = 0; x <= xmax; x++) begin
            DrawX = 10'(x);
            blank = (x < 640) && (y < 480);
            @(posedge vga_clk); #1;
            addr_at[x] = rom_address;
            if (x >= 2) begin
                r_at[x-2] = red; g_at[x-2] = green; b_at[x-2] = blue; hit_at[x-2] = hit;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; DrawX = 10'd5; DrawY = 10'd5; blank = 1'b1;
        repeat (3) @(posedge vga_clk);
        #1;
        checks++; if (red !== 4'd0 || green !== 4'd0 || blue !== 4'd0) begin failures++; $display("FAIL reset_rgb got=%h%h%h exp=000", red, green, blue); end
        checks++; if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", hit); end
        checks++; if (rom_address !== 11'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rom_address); end
        Reset = 1'b0;
    endtask

    task automatic test_basic();
        sprite_x = 10'd100; sprite_y = 10'd50; flip_h = 1'b0;
        run_line(0, 2);
        for (int unsigned y = 49; y <= 91; y++) begin
            run_line(y, 160);
            if (y == 49) begin
                checks++; if (hit_at[100] !== 1'b0 || r_at[100] !== 4'hA) begin failures++; $display("FAIL above_box hit=%b red=%h exp hit=0 red=a", hit_at[100], r_at[100]); end
            end
            if (y == 50) begin
                checks++; if (addr_at[100] !== 11'd0) begin failures++; $display("FAIL addr_x100 got=%0d exp=0", addr_at[100]); end
                checks++; if (addr_at[101] !== 11'd0) begin failures++; $display("FAIL addr_x101 got=%0d exp=0", addr_at[101]); end
                checks++; if (addr_at[102] !== 11'd1) begin failures++; $display("FAIL addr_x102 got=%0d exp=1", addr_at[102]); end
                checks++; if (addr_at[139] !== 11'd19) begin failures++; $display("FAIL addr_x139 got=%0d exp=19", addr_at[139]); end
                checks++; if (hit_at[99] !== 1'b0 || r_at[99] !== 4'hA || g_at[99] !== 4'hB || b_at[99] !== 4'hC) begin failures++; $display("FAIL left_edge_x99 hit=%b rgb=%h%h%h exp hit=0 rgb=abc", hit_at[99], r_at[99], g_at[99], b_at[99]); end
                checks++; if (hit_at[100] !== 1'b1 || r_at[100] !== 4'h1 || g_at[100] !== 4'h5 || b_at[100] !== 4'h0) begin failures++; $display("FAIL first_pixel_x100 hit=%b rgb=%h%h%h exp hit=1 rgb=150", hit_at[100], r_at[100], g_at[100], b_at[100]); end
                checks++; if (r_at[102] !== 4'h2 || hit_at[102] !== 1'b1) begin failures++; $display("FAIL pixel_x102 hit=%b red=%h exp hit=1 red=2", hit_at[102], r_at[102]); end
                checks++; if (hit_at[139] !== 1'b1) begin failures++; $display("FAIL last_col_x139 hit=%b exp=1", hit_at[139]); end
                checks++; if (hit_at[140] !== 1'b0 || r_at[140] !== 4'hA) begin failures++; $display("FAIL right_edge_x140 hit=%b red=%h exp hit=0 red=a", hit_at[140], r_at[140]); end
                checks++; if (hit_at[110] !== 1'b0 || r_at[110] !== 4'hA || g_at[110] !== 4'hB || b_at[110] !== 4'hC) begin failures++; $display("FAIL transparent_x110 hit=%b rgb=%h%h%h exp hit=0 rgb=abc", hit_at[110], r_at[110], g_at[110], b_at[110]); end
                checks++; if (hit_at[111] !== 1'b0 || r_at[111] !== 4'hA) begin failures++; $display("FAIL transparent_x111 hit=%b red=%h exp hit=0 red=a", hit_at[111], r_at[111]); end
                checks++; if (hit_at[112] !== 1'b1 || r_at[112] !== 4'h7) begin failures++; $display("FAIL after_transparent_x112 hit=%b red=%h exp hit=1 red=7", hit_at[112], r_at[112]); end
            end
            if (y == 51) begin
                checks++; if (addr_at[100] !== 11'd0) begin failures++; $display("FAIL row0_repeat_y51 got=%0d exp=0", addr_at[100]); end
            end
            if (y == 52) begin
                checks++; if (addr_at[100] !== 11'd20) begin failures++; $display("FAIL row1_y52 got=%0d exp=20", addr_at[100]); end
            end
            if (y == 89) begin
                checks++; if (addr_at[100] !== 11'd380 || hit_at[100] !== 1'b1) begin failures++; $display("FAIL row19_y89 addr=%0d hit=%b exp addr=380 hit=1", addr_at[100], hit_at[100]); end
            end
            if (y == 90) begin
                checks++; if (hit_at[100] !== 1'b0) begin failures++; $display("FAIL below_box_y90 hit=%b exp=0", hit_at[100]); end
            end
        end
    endtask

    task automatic test_flip();
        sprite_x = 10'd100; sprite_y = 10'd50; flip_h = 1'b1;
        run_line(0, 2);
        run_line(49, 0);
        run_line(50, 160);
        checks++; if (addr_at[100] !== 11'd19) begin failures++; $display("FAIL flip_x100 got=%0d exp=19", addr_at[100]); end
        checks++; if (addr_at[101] !== 11'd19) begin failures++; $display("FAIL flip_x101 got=%0d exp=19", addr_at[101]); end
        checks++; if (addr_at[138] !== 11'd0) begin failures++; $display("FAIL flip_x138 got=%0d exp=0", addr_at[138]); end
        flip_h = 1'b0; sprite_x = 10'd200;
        run_line(51, 0);
        run_line(52, 160);
        checks++; if (addr_at[100] !== 11'd39 || hit_at[100] !== 1'b1) begin failures++; $display("FAIL midframe_change addr=%0d hit=%b exp addr=39 hit=1", addr_at[100], hit_at[100]); end
        sprite_x = 10'd100;
        run_line(0, 2);
        run_line(50, 102);
        checks++; if (addr_at[100] !== 11'd0) begin failures++; $display("FAIL unflip_next_frame got=%0d exp=0", addr_at[100]); end
    endtask

    task automatic test_anim();
        int unsigned exp;
        sprite_x = 10'd100; sprite_y = 10'd50; flip_h = 1'b0;
        anim_en = 1'b1;
        for (int unsigned k = 1; k <= 34; k++) begin
            if (k == 21) begin
                anim_en = 1'b0;
                for (int f = 0; f < 10; f++) begin
                    run_line(0, 2);
                    run_line(50, 102);
                    checks++; if (addr_at[100] !== 11'd800) begin failures++; $display("FAIL anim_frozen f=%0d got=%0d exp=800", f, addr_at[100]); end
                end
                anim_en = 1'b1;
            end
            run_line(0, 2);
            run_line(50, 102);
            exp = ((k / 8) % 4) * 400;
            checks++; if (addr_at[100] !== 11'(exp)) begin failures++; $display("FAIL anim_base k=%0d got=%0d exp=%0d", k, addr_at[100], exp); end
        end
        anim_en = 1'b0;
    endtask

    task automatic test_clip();
        sprite_x = 10'd630; sprite_y = 10'd50;
        run_line(0, 2);
        run_line(50, 650);
        checks++; if (hit_at[629] !== 1'b0) begin failures++; $display("FAIL clip_x629 hit=%b exp=0", hit_at[629]); end
        checks++; if (hit_at[630] !== 1'b1 || r_at[630] !== 4'h1) begin failures++; $display("FAIL clip_x630 hit=%b red=%h exp hit=1 red=1", hit_at[630], r_at[630]); end
        checks++; if (hit_at[639] !== 1'b1 || r_at[639] !== 4'h5) begin failures++; $display("FAIL clip_x639 hit=%b red=%h exp hit=1 red=5", hit_at[639], r_at[639]); end
        checks++; if (hit_at[640] !== 1'b0 || r_at[640] !== 4'h0 || g_at[640] !== 4'h0) begin failures++; $display("FAIL clip_x640 hit=%b rg=%h%h exp hit=0 rg=00", hit_at[640], r_at[640], g_at[640]); end
        run_line(51, 20);
        for (int x = 0; x < 10; x++) begin
            checks++; if (hit_at[x] !== 1'b0) begin failures++; $display("FAIL no_wrap x=%0d hit=%b exp=0", x, hit_at[x]); end
        end
        checks++; if (r_at[5] !== 4'hA) begin failures++; $display("FAIL no_wrap_bg red=%h exp=a", r_at[5]); end
        sprite_x = 10'd100; sprite_y = 10'd470;
        run_line(0, 2);
        for (int unsigned y = 469; y <= 482; y++) begin
            run_line(y, 160);
            if (y == 469) begin
                checks++; if (hit_at[100] !== 1'b0) begin failures++; $display("FAIL vclip_y469 hit=%b exp=0", hit_at[100]); end
            end
            if (y == 470) begin
                checks++; if (hit_at[100] !== 1'b1) begin failures++; $display("FAIL vclip_y470 hit=%b exp=1", hit_at[100]); end
            end
            if (y == 479) begin
                checks++; if (hit_at[100] !== 1'b1 || addr_at[100] !== 11'd80) begin failures++; $display("FAIL vclip_y479 hit=%b addr=%0d exp hit=1 addr=80", hit_at[100], addr_at[100]); end
            end
            if (y == 480) begin
                checks++; if (hit_at[100] !== 1'b0 || r_at[100] !== 4'h0) begin failures++; $display("FAIL vclip_y480 hit=%b red=%h exp hit=0 red=0", hit_at[100], r_at[100]); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic any_hit;
        sprite_x = 10'd100; sprite_y = 10'd50;
        run_line(0, 2);
        for (int unsigned y = 49; y <= 59; y++) run_line(y, 0);
        run_line(60, 104);
        checks++; if (hit_at[102] !== 1'b1) begin failures++; $display("FAIL pre_reset_y60 hit=%b exp=1", hit_at[102]); end
        Reset = 1'b1; DrawX = 10'd105;
        @(posedge vga_clk); #1;
        checks++; if (red !== 4'd0 || green !== 4'd0 || blue !== 4'd0 || hit !== 1'b0) begin failures++; $display("FAIL midframe_reset_out rgb=%h%h%h hit=%b exp 000 0", red, green, blue, hit); end
        checks++; if (rom_address !== 11'd0) begin failures++; $display("FAIL midframe_reset_addr got=%0d exp=0", rom_address); end
        Reset = 1'b0;
        any_hit = 1'b0;
        for (int unsigned y = 60; y <= 70; y++) begin
            run_line(y, 160);
            for (int x = 0; x <= 158; x++) if (hit_at[x] !== 1'b0) any_hit = 1'b1;
        end
        checks++; if (any_hit !== 1'b0) begin failures++; $display("FAIL suppressed_after_reset any_hit=%b exp=0", any_hit); end
        run_line(0, 2);
        run_line(50, 160);
        checks++; if (hit_at[100] !== 1'b1 || addr_at[100] !== 11'd0 || r_at[100] !== 4'h1) begin failures++; $display("FAIL reappear_next_frame hit=%b addr=%0d red=%h exp 1 0 1", hit_at[100], addr_at[100], r_at[100]); end
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) rom[a] = 5'((a % 31) + 1);
        rom[5] = 5'd0;
        sprite_x = '0; sprite_y = '0; flip_h = 1'b0; anim_en = 1'b0;
        bg_red = 4'hA; bg_green = 4'hB; bg_blue = 4'hC;
        DrawX = '0; DrawY = '0; blank = 1'b0; Reset = 1'b1;
        test_reset();
        test_basic();
        test_flip();
        test_anim();
        test_clip();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
